// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants, state encoding and vector address helper for the
// interrupt entry sequencer.
package interrupt_sequencer_pkg;

  localparam logic [15:0] IVT_BASE  = 16'hFF80;
  localparam logic [5:0]  IVT_RESET = 6'd63;
  localparam logic [5:0]  IDX_RESET = IVT_RESET;
  localparam logic [5:0]  NMI_MIN   = 6'd62;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_PUSH_PC  = 3'd2,
    ST_PUSH_SR  = 3'd3,
    ST_VEC_RD   = 3'd4,
    ST_VEC_LD   = 3'd5
  } state_t;

  function automatic logic [15:0] vec_addr(input logic [5:0] idx);
    return IVT_BASE + {9'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// CPU-side interrupt acceptance and MSP430-style entry sequence:
// push PC, push SR, clear SR, fetch vector, load PC. Also owns the reset vector fetch.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
(
  input  logic        MCLK,
  input  logic        RSTn,
  input  logic        IntReq,
  input  logic [5:0]  IntAddr,
  input  logic        GIE,
  input  logic        InstrBoundary,
  input  logic [15:0] SPin,
  input  logic [15:0] PCin,
  input  logic [15:0] SRin,
  input  logic [15:0] MDBin,
  output logic [15:0] MAB,
  output logic [15:0] MDBout,
  output logic        MW,
  output logic        MR,
  output logic [15:0] SPout,
  output logic        SPload,
  output logic [15:0] PCout,
  output logic        PCload,
  output logic        SRclr,
  output logic        INTACK,
  output logic        Busy,
  output state_t      dbg_state_o
);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic       rst_req;
  logic       accept;

  // A reset request wins over everything, in any state.
  assign rst_req = IntReq && (IntAddr == IDX_RESET);
  assign accept  = InstrBoundary && IntReq && (GIE || (IntAddr >= NMI_MIN))
                   && (IntAddr != IDX_RESET);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PUSH_PC;
          idx_d   = IntAddr;
        end
      end
      ST_RST_HOLD: state_d = ST_VEC_RD;
      ST_PUSH_PC:  state_d = ST_PUSH_SR;
      ST_PUSH_SR:  state_d = ST_VEC_RD;
      ST_VEC_RD:   state_d = ST_VEC_LD;
      ST_VEC_LD:   state_d = ST_IDLE;
      default:     state_d = ST_RST_HOLD;
    endcase
    if (rst_req) begin
      state_d = ST_RST_HOLD;
      idx_d   = IDX_RESET;
    end
  end

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_RST_HOLD;
      idx_q   <= IDX_RESET;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // SP is always pre-decremented by 2; odd bit passes through untouched.
  assign SPout       = SPin - 16'd2;
  assign PCout       = MDBin;
  assign Busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    MAB    = '0;
    MDBout = '0;
    MW     = 1'b0;
    MR     = 1'b0;
    SPload = 1'b0;
    PCload = 1'b0;
    SRclr  = 1'b0;
    INTACK = 1'b0;
    case (state_q)
      ST_RST_HOLD: SRclr = 1'b1;
      ST_PUSH_PC: begin
        MAB    = SPin - 16'd2;
        MDBout = PCin;
        MW     = 1'b1;
        SPload = 1'b1;
      end
      ST_PUSH_SR: begin
        MAB    = SPin - 16'd2;
        MDBout = SRin;
        MW     = 1'b1;
        SPload = 1'b1;
      end
      ST_VEC_RD: begin
        MAB    = vec_addr(idx_q);
        MR     = 1'b1;
        SRclr  = 1'b1;
        INTACK = (idx_q != IDX_RESET);
      end
      ST_VEC_LD: PCload = 1'b1;
      default: ;
    endcase
    // Suppress strobes in the cycle a reset request arrives: no partial write.
    if (rst_req) begin
      MW     = 1'b0;
      MR     = 1'b0;
      SPload = 1'b0;
      PCload = 1'b0;
      INTACK = 1'b0;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized and directed bench: expected bus transactions per interrupt are
// queued from the entry-sequence rules and matched against observed strobes.
module tb_interrupt_sequencer;
  import interrupt_sequencer_pkg::*;

  logic        MCLK = 1'b0;
  logic        RSTn;
  logic        IntReq;
  logic [5:0]  IntAddr;
  logic        GIE;
  logic        InstrBoundary;
  logic [15:0] SPin, PCin, SRin, MDBin;
  logic [15:0] MAB, MDBout, SPout, PCout;
  logic        MW, MR, SPload, PCload, SRclr, INTACK, Busy;
  state_t      dbg_state;

  interrupt_sequencer dut (
    .MCLK(MCLK), .RSTn(RSTn), .IntReq(IntReq), .IntAddr(IntAddr), .GIE(GIE),
    .InstrBoundary(InstrBoundary), .SPin(SPin), .PCin(PCin), .SRin(SRin),
    .MDBin(MDBin), .MAB(MAB), .MDBout(MDBout), .MW(MW), .MR(MR),
    .SPout(SPout), .SPload(SPload), .PCout(PCout), .PCload(PCload),
    .SRclr(SRclr), .INTACK(INTACK), .Busy(Busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 MCLK = ~MCLK;

  int checks   = 0;
  int failures = 0;

  // event = {kind[3:0], addr[15:0], data[15:0]}; kind 1=write 2=read 3=pc load 4=stray ack
  logic [35:0] exp_q[$];
  logic        busy_s, pcload_s, spload_s;
  logic [15:0] spout_s;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [35:0] ev(input logic [3:0] kind, input logic [15:0] a,
                                     input logic [15:0] d);
    return {kind, a, d};
  endfunction

  task automatic observe(input logic [35:0] e);
    if (exp_q.size() == 0) check("extra_ev", e, 36'd0);
    else check("bus_ev", e, exp_q.pop_front());
  endtask

  task automatic sample();
    busy_s   = Busy;
    pcload_s = PCload;
    spload_s = SPload;
    spout_s  = SPout;
    if (MW) observe(ev(4'd1, MAB, MDBout));
    if (MR) begin
      observe(ev(4'd2, MAB, {15'd0, INTACK}));
      check("srclr_vec_rd", {35'd0, SRclr}, 36'd1);
    end else if (INTACK) observe(ev(4'd4, 16'd0, 16'd0));
    if (PCload) observe(ev(4'd3, PCout, 16'd0));
  endtask

  // one clock: sample mid-cycle, then act as the CPU register file after the edge
  task automatic step();
    @(negedge MCLK);
    sample();
    @(posedge MCLK);
    #1;
    if (spload_s) SPin = spout_s;
  endtask

  // reference: one interrupt offered at a boundary cycle
  task automatic run_irq(input logic [5:0] idx, input logic gie, input logic bnd,
                         input logic [15:0] sp, input logic [15:0] pc,
                         input logic [15:0] sr, input logic [15:0] vec);
    logic acc;
    acc = bnd && (gie || idx >= 6'd62) && idx != 6'd63;
    IntReq = 1'b1; IntAddr = idx; GIE = gie; InstrBoundary = bnd;
    SPin = sp; PCin = pc; SRin = sr; MDBin = vec;
    if (acc) begin
      exp_q.push_back(ev(4'd1, sp - 16'd2, pc));
      exp_q.push_back(ev(4'd1, sp - 16'd4, sr));
      exp_q.push_back(ev(4'd2, 16'hFF80 + 16'(idx) * 16'd2, 16'd1));
      exp_q.push_back(ev(4'd3, vec, 16'd0));
    end
    step();
    check("busy_idle", {35'd0, busy_s}, 36'd0);
    IntReq = 1'b0; InstrBoundary = 1'b0;
    if (acc) GIE = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("busy_seq", {35'd0, busy_s}, {35'd0, acc && k <= 4});
      check("pcload_lat", {35'd0, pcload_s}, {35'd0, acc && k == 4});
    end
    check("missing_ev", 36'(exp_q.size()), 36'd0);
    exp_q.delete();
  endtask

  initial begin
    RSTn = 1'b0; IntReq = 1'b0; IntAddr = 6'd0; GIE = 1'b0; InstrBoundary = 1'b0;
    SPin = 16'h0400; PCin = 16'h0000; SRin = 16'h0000; MDBin = 16'hC000;

    // power-up: reset vector fetch
    @(negedge MCLK);
    check("rst_busy", {35'd0, Busy}, 36'd1);
    check("rst_srclr", {35'd0, SRclr}, 36'd1);
    check("rst_strobes", {31'd0, MW, MR, SPload, PCload, INTACK}, 36'd0);
    check("rst_state", {33'd0, dbg_state}, {33'd0, ST_RST_HOLD});
    @(posedge MCLK); #1;
    RSTn = 1'b1;
    exp_q.push_back(ev(4'd2, 16'hFFFE, 16'd0));
    exp_q.push_back(ev(4'd3, 16'hC000, 16'd0));
    for (int k = 1; k <= 4; k++) begin
      step();
      check("pu_busy", {35'd0, busy_s}, {35'd0, k <= 3});
    end
    check("pu_missing", 36'(exp_q.size()), 36'd0);
    exp_q.delete();

    // directed cases
    run_irq(6'd10, 1'b1, 1'b1, 16'h0400, 16'hC124, 16'h0008, 16'hD000);
    run_irq(6'd10, 1'b0, 1'b1, 16'h0400, 16'hC124, 16'h0008, 16'hD000);
    run_irq(6'd62, 1'b0, 1'b1, 16'h0400, 16'hC200, 16'h0000, 16'hD100);
    run_irq(6'd5,  1'b1, 1'b1, 16'h0000, 16'h1234, 16'h0001, 16'hABCD);
    run_irq(6'd7,  1'b1, 1'b1, 16'h0301, 16'h2222, 16'h0009, 16'h3333);

    // no boundary for 10 cycles, then accept on first boundary
    IntReq = 1'b1; IntAddr = 6'd20; GIE = 1'b1; InstrBoundary = 1'b0; SPin = 16'h0500;
    for (int k = 0; k < 10; k++) begin
      step();
      check("nobnd_busy", {35'd0, busy_s}, 36'd0);
    end
    run_irq(6'd20, 1'b1, 1'b1, 16'h0500, 16'h4444, 16'h0008, 16'h5555);

    // reset request lands during PUSH_SR
    IntReq = 1'b1; IntAddr = 6'd10; GIE = 1'b1; InstrBoundary = 1'b1;
    SPin = 16'h0400; PCin = 16'hC124; SRin = 16'h0008; MDBin = 16'hE000;
    exp_q.push_back(ev(4'd1, 16'h03FE, 16'hC124));
    step();
    IntReq = 1'b0; InstrBoundary = 1'b0; GIE = 1'b0;
    step();
    IntReq = 1'b1; IntAddr = 6'd63;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rh_busy", {35'd0, busy_s}, 36'd1);
    end
    check("rh_sp_kept", {20'd0, SPin}, 36'h03FE);
    IntReq = 1'b0;
    exp_q.push_back(ev(4'd2, 16'hFFFE, 16'd0));
    exp_q.push_back(ev(4'd3, 16'hE000, 16'd0));
    for (int k = 1; k <= 4; k++) begin
      step();
      check("rh_exit_busy", {35'd0, busy_s}, {35'd0, k <= 3});
    end
    check("rh_missing", 36'(exp_q.size()), 36'd0);
    exp_q.delete();

    // randomized interrupts
    for (int n = 0; n < 40; n++) begin
      run_irq(6'($urandom_range(0, 62)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
CPU-side end of the interrupt daisy chain. Consumes the chain head's request and vector index, then decides acceptance at instruction boundaries. On acceptance it runs the MSP430 entry sequence: push PC, push SR, clear SR, read the vector, load PC. It returns INTACK into the chain head, and it owns the post-reset vector fetch. It sits between the chain head and the CPU datapath/memory bus.

Parameters:
IVT_BASE, 16'hFF80, byte address of vector index 0; vector address = IVT_BASE + {idx,1'b0}
IDX_RESET, 6'd63, reset vector index (matches global IVT_RESET)
NMI_MIN, 6'd62, indices >= NMI_MIN are non-maskable (ignore GIE)

Ports:
MCLK  in  1  system clock
RSTn  in  1  async active-low reset
IntReq  in  1  request from chain head
IntAddr  in  6  vector index from chain head
GIE  in  1  SR.GIE from CPU
InstrBoundary  in  1  CPU completing an instruction this cycle; next fetch would begin
SPin  in  16  current SP
PCin  in  16  return PC (next instruction address)
SRin  in  16  current SR
MDBin  in  16  memory read data, valid the cycle after MR
MAB  out  16  memory address
MDBout  out  16  memory write data
MW  out  1  write strobe
MR  out  1  read strobe
SPout  out  16  new SP value
SPload  out  1  load SPout into SP
PCout  out  16  new PC value
PCload  out  1  load PCout into PC
SRclr  out  1  clear SR (GIE, CPUOFF, OSCOFF, SCG1; CPU keeps SCG0)
INTACK  out  1  acknowledge into chain head, 1-cycle pulse
Busy  out  1  stall CPU fetch/execute

Behaviour:
- States: IDLE, RST_HOLD, PUSH_PC, PUSH_SR, VEC_RD, VEC_LD. Registered state and latched idx[5:0]. All outputs are combinational from state, idx, and inputs.
- Async reset (RSTn=0): state=RST_HOLD, idx=IDX_RESET, Busy=1. MW, MR, SPload, PCload, INTACK are 0. SRclr=1.
- IDLE: Busy=0, all strobes 0.
- Accept in IDLE requires InstrBoundary & IntReq & (GIE | IntAddr>=NMI_MIN) & IntAddr!=IDX_RESET. On accept: latch idx=IntAddr, next state PUSH_PC.
- PUSH_PC: MAB=SPin-2, MDBout=PCin, MW=1, SPout=SPin-2, SPload=1.
- PUSH_SR: MAB=SPin-2 (SPin already updated), MDBout=SRin, MW=1, SPout=SPin-2, SPload=1.
- VEC_RD: MAB=IVT_BASE+{idx,0}, MR=1, SRclr=1. INTACK=1 only if idx!=IDX_RESET.
- VEC_LD: PCout=MDBin, PCload=1. Next state is IDLE.
- Latency: accept cycle to PCload is 4 cycles. Busy=1 in every non-IDLE state.
- SP arithmetic is mod 2^16. No overflow check. SP odd bit is passed through unchanged.
- Reset request: IntReq & IntAddr==IDX_RESET in ANY state forces next state RST_HOLD and idx=IDX_RESET. This overrides accept and aborts a sequence in progress. The current cycle's strobes are suppressed, so there is no partial write.
- RST_HOLD: SRclr=1, no strobes. Exit to VEC_RD when the reset request is gone. SP is not pushed on the reset path.
- IntReq drops after accept: the sequence completes with the latched idx. INTACK is still pulsed; the chain tolerates this.
- A new request during the sequence is not sampled until the next IDLE boundary. GIE is 0 by then unless idx is NMI.
- InstrBoundary outside IDLE is ignored.

Decomposition:
- Shared package/PARAMS: IVT_BASE, IVT_RESET, NMI_MIN, state encoding constants.
- No sub-module needed. Optionally split vector address formation into interrupt_vec_addr; kept inline by default.

Test Plan:
- Power-up: RSTn low→high, IntReq=0, MDBin=16'hC000 in VEC_LD → MR at MAB=FFFE, PCload with PCout=C000, no MW, INTACK=0, Busy falls after.
- Maskable: GIE=1, idx=10, SP=0400, PC=C124, SR=0008, boundary → writes C124@03FE, 0008@03FC. MAB=FF94 with INTACK pulse. PC loaded from MDBin. SRclr in VEC_RD.
- Masked: GIE=0, idx=10, boundary → stays IDLE, no strobes. Same with idx=62 → accepted.
- Reset mid-sequence: assert IntReq with IntAddr=63 during PUSH_SR → that cycle MW suppressed, RST_HOLD until release, then FFFE fetch, no INTACK.
- SP wrap: SP=0000 → pushes at FFFE then FFFC, SPout=FFFC.
- No boundary: IntReq held with InstrBoundary=0 for 10 cycles → remains IDLE; accepts on first boundary.
